// File: rtl/packet_tx_if.sv
// Request channel and framed beat stream between packet_tx and its user.
// master = the framer side, slave = the request source / downstream sink side.
interface packet_tx_if #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [LEN_W-1:0]  req_len;
    logic [DATA_W-1:0] req_seed;
    logic              req_drop_eop;
    logic              tx_ready;
    logic              data_valid;
    logic [DATA_W-1:0] packet_data_out;
    logic              start_of_packet;
    logic              end_of_packet;

    modport master (
        input  req_valid, req_len, req_seed, req_drop_eop, tx_ready,
        output req_ready, data_valid, packet_data_out, start_of_packet, end_of_packet
    );

    modport slave (
        output req_valid, req_len, req_seed, req_drop_eop, tx_ready,
        input  req_ready, data_valid, packet_data_out, start_of_packet, end_of_packet
    );
endinterface

// File: rtl/packet_tx.sv
// Transmit framer: turns one (len, seed, drop_eop) request into a run of
// SOP/EOP-framed beats seed, seed+1, ... with downstream stall support.
module packet_tx #(
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 4,
    parameter int MAX_LEN    = 8,
    parameter int GAP_CYCLES = 1,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    packet_tx_if.master      bus,
    output logic             tx_busy,
    output logic [CNT_W-1:0] tx_packet_counter,
    output logic [CNT_W-1:0] tx_reject_counter
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int GAP_W = 4;

    state_t            state_reg, state_next;
    logic [LEN_W-1:0]  idx_reg, idx_next;
    logic [LEN_W-1:0]  len_reg, len_next;
    logic [DATA_W-1:0] seed_reg, seed_next;
    logic              drop_reg, drop_next;
    logic [GAP_W-1:0]  gap_reg, gap_next;
    logic [CNT_W-1:0]  pkt_cnt_reg, pkt_cnt_next;
    logic [CNT_W-1:0]  rej_cnt_reg, rej_cnt_next;

    logic len_ok;
    logic fire;
    logic last_beat;

    // Legal lengths are 1..MAX_LEN; the extra bit keeps the compare unsigned and overflow-free.
    assign len_ok    = (bus.req_len != '0) &&
                       ({1'b0, bus.req_len} <= (LEN_W+1)'(MAX_LEN));
    assign fire      = (state_reg == SEND) && bus.tx_ready;
    assign last_beat = (idx_reg == (len_reg - LEN_W'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            len_reg     <= '0;
            seed_reg    <= '0;
            drop_reg    <= 1'b0;
            gap_reg     <= '0;
            pkt_cnt_reg <= '0;
            rej_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            len_reg     <= len_next;
            seed_reg    <= seed_next;
            drop_reg    <= drop_next;
            gap_reg     <= gap_next;
            pkt_cnt_reg <= pkt_cnt_next;
            rej_cnt_reg <= rej_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        len_next     = len_reg;
        seed_next    = seed_reg;
        drop_next    = drop_reg;
        gap_next     = gap_reg;
        pkt_cnt_next = pkt_cnt_reg;
        rej_cnt_next = rej_cnt_reg;

        case (state_reg)
            IDLE: begin
                if (bus.req_valid) begin
                    len_next  = bus.req_len;
                    seed_next = bus.req_seed;
                    drop_next = bus.req_drop_eop;
                    idx_next  = '0;
                    if (len_ok) begin
                        state_next = SEND;
                    end else begin
                        rej_cnt_next = rej_cnt_reg + CNT_W'(1);
                    end
                end
            end
            SEND: begin
                // Index only moves on an accepted beat, so a stall holds data in place.
                if (fire) begin
                    if (last_beat) begin
                        pkt_cnt_next = pkt_cnt_reg + CNT_W'(1);
                        gap_next     = GAP_W'(GAP_CYCLES - 1);
                        state_next   = GAP;
                    end else begin
                        idx_next = idx_reg + LEN_W'(1);
                    end
                end
            end
            GAP: begin
                if (gap_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    gap_next = gap_reg - GAP_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Stream outputs are purely combinational from state and tx_ready.
    assign bus.req_ready       = (state_reg == IDLE) && !rst;
    assign bus.data_valid      = fire;
    assign bus.packet_data_out = (state_reg == SEND) ? (seed_reg + DATA_W'(idx_reg)) : '0;
    assign bus.start_of_packet = fire && (idx_reg == '0);
    assign bus.end_of_packet   = fire && last_beat && !drop_reg;

    assign tx_busy           = (state_reg != IDLE);
    assign tx_packet_counter = pkt_cnt_reg;
    assign tx_reject_counter = rej_cnt_reg;
endmodule

// File: doc/packet_tx.md
Name: packet_tx

Overview:
- Transmit-side framer for the 32-bit SOP/EOP packet stream consumed by the packet parser.
- Takes one packet request at a time (length, seed word, error-injection flag).
- Emits the packet as consecutive data beats with start_of_packet / end_of_packet framing and honours a downstream stall input.
- Used as the traffic source in front of the parser in system benches, and as a reusable TX framer.

Parameters:
DATA_W, 32, width of packet data word
LEN_W, 4, width of req_len
MAX_LEN, 8, largest legal packet length in beats; longer requests are rejected
GAP_CYCLES, 1, idle cycles forced between packets (1..15)
CNT_W, 4, width of status counters (wrap-around)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
req_valid  in  1  packet request present
req_ready  out  1  block can accept a request (high only in IDLE)
req_len  in  LEN_W  packet length in beats, SOP beat through EOP beat inclusive
req_seed  in  DATA_W  data of first beat
req_drop_eop  in  1  error injection: suppress EOP on last beat
tx_ready  in  1  downstream accepts a beat this cycle
data_valid  out  1  beat present on packet_data_out
packet_data_out  out  DATA_W  beat data
start_of_packet  out  1  first beat of packet
end_of_packet  out  1  last beat of packet
tx_busy  out  1  state != IDLE
tx_packet_counter  out  CNT_W  packets completed (includes drop_eop packets)
tx_reject_counter  out  CNT_W  requests rejected for illegal length

Behaviour:
- Reset (async, active-high): state IDLE, beat index 0, latched request cleared, both counters 0. All outputs 0 except req_ready = 1 once reset releases.
- FSM states: IDLE, SEND, GAP.
- IDLE: req_ready = 1. On req_valid at a clock edge, latch req_len, req_seed and req_drop_eop.
  - req_len == 0 or req_len > MAX_LEN: tx_reject_counter += 1; stay IDLE; nothing emitted.
  - Otherwise: go to SEND with index = 0.
- SEND: req_ready = 0.
  - Beat fires in any cycle with tx_ready = 1.
  - data_valid = (state == SEND) & tx_ready, combinational.
  - packet_data_out = seed + index, modulo 2^DATA_W. Wraps FFFFFFFF -> 00000000. Held at the current beat value while stalled.
  - start_of_packet = data_valid & (index == 0).
  - end_of_packet = data_valid & (index == len-1) & ~drop_eop.
  - len == 1: start_of_packet and end_of_packet are asserted in the same beat.
  - Index advances only on a fired beat.
- Stall: tx_ready = 0 drives data_valid, start_of_packet and end_of_packet low. Index and data hold. Stalls of any length are legal, including on the SOP beat and the EOP beat.
- Last beat fired: tx_packet_counter += 1 (wraps 15 -> 0); go to GAP.
- GAP: all stream outputs 0 for exactly GAP_CYCLES cycles, then IDLE.
- Latency: request accepted at edge N -> first beat eligible in the cycle after edge N. Back-to-back packets with tx_ready = 1 and req_valid held high: SOP spacing = len + GAP_CYCLES + 1 cycles.
- req_* inputs are ignored outside IDLE; the latched values govern the whole packet.
- Reset mid-packet: stream outputs drop immediately, no EOP is emitted, the packet is not counted, and the counters clear.

Test Plan:
- Reset, then request len=4, seed=0x10, tx_ready=1 -> beats 0x10,0x11,0x12,0x13 on consecutive cycles; SOP on beat 0 only; EOP on beat 3 only; tx_packet_counter=1; req_ready high again after 1 GAP cycle.
- len=5, seed=0x100, tx_ready low for 2 cycles after beat 1 -> data_valid low during stall; data holds 0x102; beats resume 0x102..0x104; exactly one SOP and one EOP.
- Requests len=0 then len=9 -> no data_valid; tx_reject_counter=2; tx_packet_counter unchanged.
- len=1, seed=0xFFFFFFFF -> single beat with SOP=EOP=1, data 0xFFFFFFFF. Then len=2, seed=0xFFFFFFFF -> data FFFFFFFF, 00000000.
- len=3 with req_drop_eop=1 -> 3 beats, SOP on first, no EOP; tx_packet_counter increments. 17 legal packets back-to-back -> counter wraps to 1.
- rst asserted during beat 2 of a len=6 packet -> outputs 0 asynchronously, counters 0. Next request len=2 after reset release transmits normally.
